// File: rtl/hamm_frame_acc_if.sv
// Handshake bundle for hamm_frame_acc: popcount weight input stream plus frame result output.
// master = the environment (upstream source and downstream sink), slave = the accumulator.
interface hamm_frame_acc_if #(
    parameter int FRAME_LEN = 16
);
    localparam int SUM_W = 6 + $clog2(FRAME_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_weight;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [5:0]       out_max;
    logic [5:0]       out_min;
    logic             out_err;

    modport master (
        output in_valid, in_weight, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_min, out_err
    );

    modport slave (
        input  in_valid, in_weight, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_min, out_err
    );
endinterface

// File: rtl/hamm_frame_acc.sv
// Frame accumulator for popcount weights: sums FRAME_LEN clamped weights and holds one result per frame.
// Define HAMM_FRAME_MINMAX_EN to build the per-frame max/min trackers; otherwise out_max/out_min read 0.
module hamm_frame_acc #(
    parameter int FRAME_LEN = 16
) (
    input logic            clk,
    input logic            rst,
    hamm_frame_acc_if.slave bus
);
    localparam int SUM_W = 6 + $clog2(FRAME_LEN);
    localparam int CNT_W = $clog2(FRAME_LEN) + 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             handshake;
    logic             last;
    logic             over;
    logic [5:0]       w;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W-1:0] out_sum_r;
    logic             err;
    logic             out_err_r;
    logic             unused_bits;

    // Upper bus bits come from the wide popcount output and can never matter here.
    assign unused_bits = ^bus.in_weight[31:6];

    assign over     = bus.in_weight[5:0] > 6'd32;
    assign w        = over ? 6'd32 : bus.in_weight[5:0];
    assign last     = count == CNT_W'(FRAME_LEN - 1);
    assign sum_next = sum + SUM_W'(w);

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            ACCUM: begin
                accept = bus.in_valid;
                if (accept && last) state_next = HOLD;
            end
            HOLD: begin
                handshake = bus.out_ready;
                if (handshake) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = out_sum_r;
    assign bus.out_err   = out_err_r;

    // Accumulators clear on the output handshake; out_* capture on the frame's final accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            sum       <= '0;
            err       <= 1'b0;
            out_sum_r <= '0;
            out_err_r <= 1'b0;
        end else if (handshake) begin
            count <= '0;
            sum   <= '0;
            err   <= 1'b0;
        end else if (accept) begin
            count <= count + 1'b1;
            sum   <= sum_next;
            err   <= err | over;
            if (last) begin
                out_sum_r <= sum_next;
                out_err_r <= err | over;
            end
        end
    end

`ifdef HAMM_FRAME_MINMAX_EN
    logic [5:0] max_r;
    logic [5:0] min_r;
    logic [5:0] max_next;
    logic [5:0] min_next;
    logic [5:0] out_max_r;
    logic [5:0] out_min_r;

    assign max_next    = (w > max_r) ? w : max_r;
    assign min_next    = (w < min_r) ? w : min_r;
    assign bus.out_max = out_max_r;
    assign bus.out_min = out_min_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_r     <= 6'd0;
            min_r     <= 6'd32;
            out_max_r <= 6'd0;
            out_min_r <= 6'd32;
        end else if (handshake) begin
            max_r <= 6'd0;
            min_r <= 6'd32;
        end else if (accept) begin
            max_r <= max_next;
            min_r <= min_next;
            if (last) begin
                out_max_r <= max_next;
                out_min_r <= min_next;
            end
        end
    end
`else
    assign bus.out_max = 6'd0;
    assign bus.out_min = 6'd0;
`endif
endmodule

// File: tb/tb_hamm_frame_acc.sv
// Directed bench for hamm_frame_acc: vector table on a FRAME_LEN=4 instance plus a full-scale FRAME_LEN=16 run.
// Expected extremes follow HAMM_FRAME_MINMAX_EN (0 when the trackers are not built).
module tb_hamm_frame_acc;
    logic clk;
    logic rst;

    hamm_frame_acc_if #(.FRAME_LEN(4))  bus4 ();
    hamm_frame_acc_if #(.FRAME_LEN(16)) bus16 ();

    hamm_frame_acc #(.FRAME_LEN(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    hamm_frame_acc #(.FRAME_LEN(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        valid;
        logic [31:0] weight;
        logic        rdy;
        logic        e_ir;
        logic        e_ov;
        logic        chk;
        logic [7:0]  e_sum;
        logic [5:0]  e_max;
        logic [5:0]  e_min;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [5:0] emx(input logic [5:0] v);
`ifdef HAMM_FRAME_MINMAX_EN
        return v;
`else
        return 6'd0;
`endif
    endfunction

    task automatic add_vec(input string name, input logic r, input logic v, input logic [31:0] wt,
                           input logic rdy, input logic e_ir, input logic e_ov, input logic chk,
                           input logic [7:0] e_sum, input logic [5:0] e_max, input logic [5:0] e_min,
                           input logic e_err);
        vec_t t;
        t.name = name; t.rst = r; t.valid = v; t.weight = wt; t.rdy = rdy;
        t.e_ir = e_ir; t.e_ov = e_ov; t.chk = chk;
        t.e_sum = e_sum; t.e_max = emx(e_max); t.e_min = emx(e_min); t.e_err = e_err;
        vecs.push_back(t);
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t t);
        @(negedge clk);
        rst            = t.rst;
        bus4.in_valid  = t.valid;
        bus4.in_weight = t.weight;
        bus4.out_ready = t.rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input vec_t t);
        cmp({t.name, ".in_ready"},  int'(bus4.in_ready),  int'(t.e_ir));
        cmp({t.name, ".out_valid"}, int'(bus4.out_valid), int'(t.e_ov));
        if (t.chk) begin
            cmp({t.name, ".out_sum"}, int'(bus4.out_sum), int'(t.e_sum));
            cmp({t.name, ".out_max"}, int'(bus4.out_max), int'(t.e_max));
            cmp({t.name, ".out_min"}, int'(bus4.out_min), int'(t.e_min));
            cmp({t.name, ".out_err"}, int'(bus4.out_err), int'(t.e_err));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus4.in_valid = 1'b0;  bus4.in_weight = '0;  bus4.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_weight = '0; bus16.out_ready = 1'b0;

        //      name        rst v  weight  rdy ir ov chk sum max min err
        add_vec("reset",     1, 0, 32'd0,  0,  1, 0, 1,  0,  0,  32, 0);
        // Basic frame, out_ready held high: result one cycle after 4th accept
        add_vec("basic_w0",  0, 1, 32'd0,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("basic_w1",  0, 1, 32'd32, 1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("basic_w2",  0, 1, 32'd5,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("basic_res", 0, 1, 32'd7,  1,  0, 1, 1,  44, 32, 0,  0);
        add_vec("basic_hs",  0, 1, 32'd9,  1,  1, 0, 0,  0,  0,  0,  0);
        // Backpressure: 1,2,3,4 then held for 5 cycles with in_valid pulsing
        add_vec("bp_w0",     0, 1, 32'd1,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp_w1",     0, 1, 32'd2,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp_w2",     0, 1, 32'd3,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp_res",    0, 1, 32'd4,  0,  0, 1, 1,  10, 4,  1,  0);
        for (int i = 0; i < 5; i++)
            add_vec("bp_hold", 0, (i % 2 == 0), 32'd9, 0, 0, 1, 1, 10, 4, 1, 0);
        add_vec("bp_hs",     0, 1, 32'd9,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp2_w0",    0, 1, 32'd2,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp2_w1",    0, 1, 32'd2,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp2_w2",    0, 1, 32'd2,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("bp2_res",   0, 1, 32'd2,  0,  0, 1, 1,  8,  2,  2,  0);
        add_vec("bp2_hs",    0, 0, 32'd0,  1,  1, 0, 0,  0,  0,  0,  0);
        // Gaps and an out-of-range weight (40 clamps to 32, flags err)
        add_vec("gap_w3",    0, 1, 32'd3,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("gap_i0",    0, 0, 32'd63, 0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("gap_w40",   0, 1, 32'd40, 0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("gap_i1",    0, 0, 32'd0,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("gap_i2",    0, 0, 32'd50, 0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("gap_w1",    0, 1, 32'd1,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("gap_res",   0, 1, 32'd2,  0,  0, 1, 1,  38, 32, 1,  1);
        add_vec("gap_hs",    0, 0, 32'd0,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("ones_w0",   0, 1, 32'd1,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("ones_w1",   0, 1, 32'd1,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("ones_w2",   0, 1, 32'd1,  0,  1, 0, 0,  0,  0,  0,  0);
        add_vec("ones_res",  0, 1, 32'd1,  0,  0, 1, 1,  4,  1,  1,  0);
        add_vec("ones_hs",   0, 0, 32'd0,  1,  1, 0, 0,  0,  0,  0,  0);
        // Reset mid-frame (with a simultaneous accept) discards the partial frame
        add_vec("mid_w0",    0, 1, 32'd9,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("mid_w1",    0, 1, 32'd9,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("mid_rst",   1, 1, 32'd9,  1,  1, 0, 1,  0,  0,  32, 0);
        add_vec("mid_a1",    0, 1, 32'd1,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("mid_a2",    0, 1, 32'd2,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("mid_a3",    0, 1, 32'd3,  1,  1, 0, 0,  0,  0,  0,  0);
        add_vec("mid_res",   0, 1, 32'd4,  0,  0, 1, 1,  10, 4,  1,  0);
        // Reset during HOLD clears the result and returns to ACCUM
        add_vec("hold_rst",  1, 0, 32'd0,  0,  1, 0, 1,  0,  0,  32, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i]);
        end

        // Full-scale frame on the 16-word instance with random upper bus bits
        @(negedge clk);
        rst = 1'b0;
        bus4.in_valid = 1'b0;
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] rw;
            @(negedge clk);
            rw = $urandom();
            rw[5:0] = 6'd32;
            bus16.in_valid  = 1'b1;
            bus16.in_weight = rw;
            @(posedge clk);
            #1;
            if (i == 14) cmp("full.out_valid_early", int'(bus16.out_valid), 0);
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        cmp("full.out_valid", int'(bus16.out_valid), 1);
        cmp("full.in_ready",  int'(bus16.in_ready),  0);
        cmp("full.out_sum",   int'(bus16.out_sum),   512);
        cmp("full.out_max",   int'(bus16.out_max),   int'(emx(6'd32)));
        cmp("full.out_min",   int'(bus16.out_min),   int'(emx(6'd32)));
        cmp("full.out_err",   int'(bus16.out_err),   0);
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cmp("full.hs_out_valid", int'(bus16.out_valid), 0);
        cmp("full.hs_in_ready",  int'(bus16.in_ready),  1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
